// File: rtl/snake_row_renderer_pkg.sv
// snake_row_renderer_pkg: shared grid defaults, cell codes, FSM state codes and cell priority
// No ports; imported by snake_row_buffer and snake_row_renderer.
package snake_row_renderer_pkg;
    localparam int DEF_GRID_WIDTH       = 32;
    localparam int DEF_GRID_HEIGHT      = 24;
    localparam int DEF_NUM_SNAKE_PIECES = 16;
    localparam int BITS_PER_CELL        = 3;
    localparam int BITS_PER_RR_STATE    = 3;

    typedef logic [BITS_PER_CELL-1:0] cell_t;

    localparam cell_t CELL_EMPTY = 3'd0;
    localparam cell_t CELL_WALL  = 3'd1;
    localparam cell_t CELL_BODY  = 3'd2;
    localparam cell_t CELL_HEAD  = 3'd3;
    localparam cell_t CELL_FOOD  = 3'd4;

    localparam logic [BITS_PER_RR_STATE-1:0] RR_IDLE  = 3'd0;
    localparam logic [BITS_PER_RR_STATE-1:0] RR_CLEAR = 3'd1;
    localparam logic [BITS_PER_RR_STATE-1:0] RR_SCAN  = 3'd2;
    localparam logic [BITS_PER_RR_STATE-1:0] RR_FOOD  = 3'd3;
    localparam logic [BITS_PER_RR_STATE-1:0] RR_DONE  = 3'd4;

    // Codes are not numerically ordered by priority, so writes compare ranks instead.
    function automatic logic [2:0] cell_rank(input cell_t c);
        return c == CELL_HEAD ? 3'd4 :
               c == CELL_BODY ? 3'd3 :
               c == CELL_FOOD ? 3'd2 :
               c == CELL_WALL ? 3'd1 : 3'd0;
    endfunction
endpackage

// File: rtl/snake_row_buffer.sv
// snake_row_buffer: double-buffered row of cell codes with clear, priority write, swap and registered read
// Ports: clk_i/rst_i clock and sync reset; clear_i/wall_row_i load walls into back row;
//        wr_en_i/wr_x_i/wr_code_i priority write into back row; swap_i copies back to front;
//        rd_x_i/rd_code_o registered lookup into front row.
module snake_row_buffer
    import snake_row_renderer_pkg::*;
#(
    parameter int W      = DEF_GRID_WIDTH,
    parameter int X_BITS = $clog2(DEF_GRID_WIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              wall_row_i,
    input  logic              wr_en_i,
    input  logic [X_BITS-1:0] wr_x_i,
    input  cell_t             wr_code_i,
    input  logic              swap_i,
    input  logic [X_BITS-1:0] rd_x_i,
    output cell_t             rd_code_o
);
    cell_t back_q  [W];
    cell_t front_q [W];
    cell_t rd_q;
    logic  wr_ok, rd_ok;

    always_comb begin
        wr_ok = wr_en_i && ({1'b0, wr_x_i} < (X_BITS+1)'(W));
        rd_ok = {1'b0, rd_x_i} < (X_BITS+1)'(W);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int x = 0; x < W; x++) begin
                back_q[x]  <= CELL_EMPTY;
                front_q[x] <= CELL_EMPTY;
            end
            rd_q <= CELL_EMPTY;
        end else begin
            if (clear_i) begin
                for (int x = 0; x < W; x++)
                    back_q[x] <= (wall_row_i || x == 0 || x == W-1) ? CELL_WALL : CELL_EMPTY;
            end else if (wr_ok && cell_rank(wr_code_i) > cell_rank(back_q[wr_x_i])) begin
                back_q[wr_x_i] <= wr_code_i;
            end
            if (swap_i)
                for (int x = 0; x < W; x++)
                    front_q[x] <= back_q[x];
            rd_q <= rd_ok ? front_q[rd_x_i] : CELL_EMPTY;
        end
    end

    assign rd_code_o = rd_q;
endmodule

// File: rtl/snake_row_renderer.sv
// snake_row_renderer: scans snake pieces one per cycle to build a grid row, then serves per-cell lookups
// Ports: clk_i/rst_i clock and sync reset; pack_snake_y_i/pack_snake_x_i packed piece coordinates;
//        food_y_i/food_x_i food cell; row_start_i/row_y_i request a row build; swap_i promote built row;
//        cell_x_i/cell_code_o registered lookup; row_ready_o, busy_o status; start_drop_o, swap_miss_o error pulses.
module snake_row_renderer
    import snake_row_renderer_pkg::*;
#(
    parameter int GRID_WIDTH       = DEF_GRID_WIDTH,
    parameter int GRID_HEIGHT      = DEF_GRID_HEIGHT,
    parameter int NUM_SNAKE_PIECES = DEF_NUM_SNAKE_PIECES,
    parameter int Y_BITS           = $clog2(GRID_HEIGHT),
    parameter int X_BITS           = $clog2(GRID_WIDTH)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [0:Y_BITS*NUM_SNAKE_PIECES-1] pack_snake_y_i,
    input  logic [0:X_BITS*NUM_SNAKE_PIECES-1] pack_snake_x_i,
    input  logic [Y_BITS-1:0]                  food_y_i,
    input  logic [X_BITS-1:0]                  food_x_i,
    input  logic                               row_start_i,
    input  logic [Y_BITS-1:0]                  row_y_i,
    input  logic                               swap_i,
    input  logic [X_BITS-1:0]                  cell_x_i,
    output logic [2:0]                         cell_code_o,
    output logic                               row_ready_o,
    output logic                               busy_o,
    output logic                               start_drop_o,
    output logic                               swap_miss_o
);
    localparam int I_BITS = $clog2(NUM_SNAKE_PIECES);

    logic [BITS_PER_RR_STATE-1:0]       state_q, state_d;
    logic [I_BITS-1:0]                  idx_q, idx_d;
    logic [Y_BITS-1:0]                  row_q, fy_q;
    logic [X_BITS-1:0]                  fx_q;
    logic [0:Y_BITS*NUM_SNAKE_PIECES-1] sy_q;
    logic [0:X_BITS*NUM_SNAKE_PIECES-1] sx_q;
    logic                               start_drop_q, swap_miss_q;
    logic [Y_BITS-1:0]                  ys [NUM_SNAKE_PIECES];
    logic [X_BITS-1:0]                  xs [NUM_SNAKE_PIECES];
    logic                               done, do_swap, take, piece_valid, wr_en;
    logic [X_BITS-1:0]                  wr_x;
    cell_t                              wr_code;

    // Packed vectors hold bit k of piece h at ascending index h*BITS+k, so unpack bit by bit.
    for (genvar h = 0; h < NUM_SNAKE_PIECES; h++) begin : g_unpack
        for (genvar k = 0; k < Y_BITS; k++) begin : g_y
            assign ys[h][k] = sy_q[h*Y_BITS+k];
        end
        for (genvar k = 0; k < X_BITS; k++) begin : g_x
            assign xs[h][k] = sx_q[h*X_BITS+k];
        end
    end

    always_comb begin
        done        = state_q == RR_DONE;
        do_swap     = done && swap_i;
        take        = row_start_i && (state_q == RR_IDLE || do_swap);
        // (0,0) marks an unused piece; the head is always live.
        piece_valid = idx_q == '0 || ys[idx_q] != '0 || xs[idx_q] != '0;
        wr_en       = state_q == RR_SCAN ? piece_valid && ys[idx_q] == row_q
                                         : state_q == RR_FOOD && fy_q == row_q;
        wr_x        = state_q == RR_SCAN ? xs[idx_q] : fx_q;
        wr_code     = state_q == RR_FOOD ? CELL_FOOD : idx_q == '0 ? CELL_HEAD : CELL_BODY;
        state_d     = take                  ? RR_CLEAR :
                      state_q == RR_CLEAR   ? RR_SCAN :
                      state_q == RR_SCAN    ? (idx_q == I_BITS'(NUM_SNAKE_PIECES-1) ? RR_FOOD : RR_SCAN) :
                      state_q == RR_FOOD    ? RR_DONE :
                      do_swap               ? RR_IDLE : state_q;
        idx_d       = state_q == RR_SCAN ? idx_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RR_IDLE;
            idx_q        <= '0;
            row_q        <= '0;
            fy_q         <= '0;
            fx_q         <= '0;
            sy_q         <= '0;
            sx_q         <= '0;
            start_drop_q <= 1'b0;
            swap_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_drop_q <= row_start_i && !take;
            swap_miss_q  <= swap_i && !done;
            if (take) begin
                row_q <= row_y_i;
                sy_q  <= pack_snake_y_i;
                sx_q  <= pack_snake_x_i;
                fy_q  <= food_y_i;
                fx_q  <= food_x_i;
            end
        end
    end

    snake_row_buffer #(.W(GRID_WIDTH), .X_BITS(X_BITS)) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (state_q == RR_CLEAR),
        .wall_row_i (row_q == '0 || row_q == Y_BITS'(GRID_HEIGHT-1)),
        .wr_en_i    (wr_en),
        .wr_x_i     (wr_x),
        .wr_code_i  (wr_code),
        .swap_i     (do_swap),
        .rd_x_i     (cell_x_i),
        .rd_code_o  (cell_code_o)
    );

    assign row_ready_o  = done;
    assign busy_o       = state_q == RR_CLEAR || state_q == RR_SCAN || state_q == RR_FOOD;
    assign start_drop_o = start_drop_q;
    assign swap_miss_o  = swap_miss_q;
endmodule

// File: tb/tb_snake_row_renderer.sv
// tb_snake_row_renderer: directed bench with a reference row model and a lookup scoreboard
module tb_snake_row_renderer;
    localparam int W = 32, H = 24, N = 16, YB = 5, XB = 5;
    typedef int row_t [W];

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:YB*N-1] pack_y;
    logic [0:XB*N-1] pack_x;
    logic [YB-1:0]   food_y, row_y;
    logic [XB-1:0]   food_x, cell_x;
    logic            row_start, swap;
    logic [2:0]      cell_code;
    logic            row_ready, busy, start_drop, swap_miss;

    int   checks = 0, errors = 0, cyc = 0, t_start = 0;
    int   px [N], py [N], fx, fy;
    row_t exp_front, pend;
    int   sb [$];

    snake_row_renderer dut (
        .clk_i(clk), .rst_i(rst), .pack_snake_y_i(pack_y), .pack_snake_x_i(pack_x),
        .food_y_i(food_y), .food_x_i(food_x), .row_start_i(row_start), .row_y_i(row_y),
        .swap_i(swap), .cell_x_i(cell_x), .cell_code_o(cell_code), .row_ready_o(row_ready),
        .busy_o(busy), .start_drop_o(start_drop), .swap_miss_o(swap_miss)
    );

    function automatic int rank(input int c);
        return c == 3 ? 4 : c == 2 ? 3 : c == 4 ? 2 : c == 1 ? 1 : 0;
    endfunction

    function automatic row_t model(input int y);
        row_t r;
        for (int x = 0; x < W; x++) r[x] = (y == 0 || y == H-1 || x == 0 || x == W-1) ? 1 : 0;
        for (int h = 0; h < N; h++)
            if ((h == 0 || px[h] != 0 || py[h] != 0) && py[h] == y && px[h] < W && rank(h == 0 ? 3 : 2) > rank(r[px[h]]))
                r[px[h]] = h == 0 ? 3 : 2;
        if (fy == y && fx < W && rank(4) > rank(r[fx])) r[fx] = 4;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int h = 0; h < N; h++) begin
            for (int k = 0; k < YB; k++) pack_y[h*YB+k] = py[h][k];
            for (int k = 0; k < XB; k++) pack_x[h*XB+k] = px[h][k];
        end
        food_y = YB'(fy);
        food_x = XB'(fx);
    endtask

    task automatic start(input int y);
        row_y = YB'(y);
        row_start = 1'b1;
        pend = model(y);
        t_start = cyc;
        tick();
        row_start = 1'b0;
    endtask

    task automatic wait_ready();
        while (!row_ready && cyc - t_start < 60) tick();
        chk("latency", cyc - t_start, 19);
    endtask

    task automatic do_swap();
        swap = 1'b1;
        exp_front = pend;
        tick();
        swap = 1'b0;
        chk("ready_fall", row_ready, 0);
    endtask

    task automatic sweep(input string tag);
        for (int x = 0; x < W; x++) begin
            cell_x = XB'(x);
            sb.push_back(exp_front[x]);
            tick();
            chk(tag, cell_code, sb.pop_front());
        end
    endtask

    initial begin
        row_start = 1'b0; swap = 1'b0; cell_x = '0; row_y = '0;
        for (int h = 0; h < N; h++) begin px[h] = 0; py[h] = 0; end
        fx = 0; fy = 0;
        apply();
        for (int x = 0; x < W; x++) exp_front[x] = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", row_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", start_drop, 0);
        chk("rst_miss", swap_miss, 0);
        sweep("rst_sweep");

        px[0] = 6; py[0] = 3; px[1] = 5; py[1] = 3; px[2] = 4; py[2] = 3; fx = 10; fy = 3;
        apply();
        start(3);
        chk("busy_clear", busy, 1);
        wait_ready();
        chk("busy_done", busy, 0);
        do_swap();
        sweep("basic");

        px[0] = 5; py[0] = 0;
        apply();
        start(0); wait_ready(); do_swap(); sweep("wall0");
        px[0] = 6; py[0] = 3;
        apply();
        start(23); wait_ready(); do_swap(); sweep("wall23");

        fx = 6; px[7] = 6; py[7] = 3;
        apply();
        start(3); wait_ready(); do_swap(); sweep("overlap");

        fx = 10;
        apply();
        start(3);
        for (int i = 0; i < 6; i++) tick();
        row_y = 20; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        chk("drop_scan", start_drop, 1);
        tick();
        chk("drop_clear", start_drop, 0);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        chk("miss_busy", swap_miss, 1);
        tick();
        chk("miss_clear", swap_miss, 0);
        wait_ready();
        row_start = 1'b1;
        tick();
        row_start = 1'b0;
        chk("drop_done", start_drop, 1);
        chk("ready_hold", row_ready, 1);
        sweep("front_kept");
        do_swap();
        sweep("after_drop");

        px[1] = 9;
        apply();
        start(3);
        wait_ready();
        row_y = 0; swap = 1'b1; row_start = 1'b1;
        exp_front = pend;
        pend = model(0);
        t_start = cyc;
        tick();
        swap = 1'b0; row_start = 1'b0;
        chk("ss_busy", busy, 1);
        chk("ss_ready", row_ready, 0);
        chk("ss_nodrop", start_drop, 0);
        wait_ready();
        sweep("ss_front");
        do_swap();
        sweep("ss_row0");

        start(3);
        for (int i = 0; i < 4; i++) tick();
        px[1] = 20; px[2] = 25; fx = 15;
        apply();
        wait_ready(); do_swap(); sweep("snapshot");

        start(5);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", row_ready, 0);
        for (int x = 0; x < W; x++) exp_front[x] = 0;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        chk("rstmid_miss", swap_miss, 1);
        sweep("rstmid_front");
        chk("rstmid_idle", row_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_row_renderer.md
Name: snake_row_renderer

Overview:
Sequential reader of the packed snake-coordinate interface (packSnakeY/packSnakeX plus food coordinates) produced by the game logic. For each grid row requested by the display side, it scans the snake pieces one per cycle and builds a per-row cell-code line into a back buffer. It then swaps that buffer to the front for per-pixel lookup. This replaces per-pixel comparison against every piece with one N-cycle scan per grid row, done during the preceding row's display time.

Parameters:
GRID_WIDTH, 32, grid columns (x range 0..GRID_WIDTH-1)
GRID_HEIGHT, 24, grid rows (y range 0..GRID_HEIGHT-1)
NUM_SNAKE_PIECES, 16, number of pieces in the packed vectors; piece 0 is the head
Y_BITS, $clog2(GRID_HEIGHT), row coordinate width
X_BITS, $clog2(GRID_WIDTH), column coordinate width

Ports:
Clock  in  1  system clock; all logic is on the rising edge
Reset  in  1  synchronous, active-high reset
packSnakeY  in  [0:Y_BITS*NUM_SNAKE_PIECES-1]  bit (h*Y_BITS+k) = bit k of piece h's y coordinate
packSnakeX  in  [0:X_BITS*NUM_SNAKE_PIECES-1]  same layout, x coordinate
foodY  in  Y_BITS  food row
foodX  in  X_BITS  food column
RowStart  in  1  one-cycle pulse: begin building row RowY
RowY  in  Y_BITS  grid row to build; sampled on RowStart
Swap  in  1  one-cycle pulse: promote the completed back row to the front
CellX  in  X_BITS  column lookup into the front row
CellCode  out  3  registered cell code for CellX
RowReady  out  1  back row complete and awaiting Swap
Busy  out  1  build in progress (states CLEAR/SCAN/FOOD)
StartDrop  out  1  one-cycle pulse: RowStart ignored
SwapMiss  out  1  one-cycle pulse: Swap with no ready row

Behaviour:
- Reset behaviour: Clock and Reset as stated; Reset is synchronous, active-high and overrides everything.
  - State goes to IDLE.
  - CellCode=0, RowReady=0, Busy=0, StartDrop=0, SwapMiss=0.
  - Every front-buffer cell is set to EMPTY.
  - Reset asserted mid-build abandons the build; no partial row ever reaches the front.
- Cell codes: EMPTY=0, WALL=1, BODY=2, HEAD=3, FOOD=4.
  - Write priority: HEAD > BODY > FOOD > WALL > EMPTY; a write never lowers a cell's code.
- FSM states: IDLE, CLEAR, SCAN, FOOD, DONE.
- IDLE, on RowStart:
  - Latch RowY.
  - Snapshot packSnakeY, packSnakeX, foodY and foodX, so game updates during the build cannot tear the row.
  - Go to CLEAR.
- CLEAR (1 cycle):
  - Back cells x=0 and x=GRID_WIDTH-1 are set to WALL; all other cells to EMPTY.
  - If RowY is 0 or GRID_HEIGHT-1, every cell is WALL.
  - i=0, go to SCAN.
- SCAN (NUM_SNAKE_PIECES cycles, piece i per cycle):
  - A piece is valid if i==0, or if its coordinate is not (0,0). Unused pieces are zeroed by the game, and (0,0) is a wall cell.
  - If valid and y==RowY, the cell at x gets HEAD when i==0, otherwise BODY.
  - After i=NUM_SNAKE_PIECES-1, go to FOOD.
- FOOD (1 cycle): if foodY==RowY, the cell at foodX gets FOOD (subject to priority). Then go to DONE.
- DONE: RowReady=1 and held until Swap.
- Latency: RowStart at cycle t gives RowReady high at t+NUM_SNAKE_PIECES+3 (t+19 at default).
- Busy is high exactly during CLEAR, SCAN and FOOD.
- Swap in DONE:
  - Back becomes front on that edge.
  - RowReady falls next cycle; state goes to IDLE.
- Swap when not in DONE: front is unchanged; SwapMiss pulses for 1 cycle.
- RowStart in CLEAR/SCAN/FOOD: ignored; StartDrop pulses for 1 cycle.
- RowStart in DONE without Swap: ignored; StartDrop pulses.
- Swap and RowStart on the same cycle in DONE: the swap is performed, the new RowY is latched, and the next state is CLEAR. No StartDrop.
- Lookup: CellCode = front[CellX] registered, 1-cycle latency. CellX >= GRID_WIDTH returns EMPTY.
  - CellX equal to a just-swapped cell reads the new front in the cycle after the Swap edge.
- Coordinates are compared at full width, with no wrap-around. Piece coordinates >= GRID_WIDTH are never written.

Decomposition:
- Constants.v gains `CELL_EMPTY/WALL/BODY/HEAD/FOOD and `BITS_PER_CELL=3, plus `RR_IDLE..`RR_DONE and `BITS_PER_RR_STATE.
- GRID_WIDTH, GRID_HEIGHT and NUM_SNAKE_PIECES defaults come from the existing grid constants.
- One sub-module: snake_row_buffer, the double-buffered GRID_WIDTH x 3-bit line. It provides:
  - clear-with-walls;
  - priority write port;
  - Swap;
  - registered read port.
- The FSM, snapshot registers and piece counter live in snake_row_renderer.

Test Plan:
- Reset, then lookup: hold Reset 2 cycles, then sweep CellX 0..31 → CellCode=0 everywhere; RowReady=0, Busy=0.
- Basic row: head (6,3), pieces 1,2 at (5,3),(4,3), rest (0,0), food (10,3). RowStart with RowY=3 → RowReady at +19. After Swap:
  - x=0 and x=31 read 1;
  - x=4 and x=5 read 2;
  - x=6 reads 3;
  - x=10 reads 4;
  - x=1 reads 0.
- Wall rows: RowY=0 and RowY=23 → all 32 cells read 1. Also with head placed at (5,0): x=5 reads 3 (priority over wall).
- Overlap priority: food at (6,3), equal to the head → x=6 reads 3. Body piece 7 also at (6,3) → still 3.
- Protocol errors:
  - RowStart at SCAN cycle 5 → StartDrop pulse, result unchanged.
  - Swap while Busy → SwapMiss pulse, front unchanged.
  - Swap+RowStart together in DONE → swap happens, Busy next cycle, no StartDrop.
- Snapshot and reset: change packSnakeX mid-SCAN → row reflects the values at RowStart. Reset mid-SCAN → front stays all 0, state IDLE.
